// File: rtl/muldiv_pkg.sv
// Shared muldiv definitions: operation encoding (funct3[1:0]), FSM states and
// the operand-signedness decode used by the multiplier.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } mul_state_t;

    // rs1 is signed for MULH and MULHSU; rs2 only for MULH.
    function automatic logic opSignedA(input mul_op_t op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic opSignedB(input mul_op_t op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/multiplier_unsigned.sv
// Shift-add core on operand magnitudes: one partial-product add per cycle for
// exactly WIDTH cycles, then a one-cycle done pulse.
module multiplier_unsigned
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_magA,
    input  logic [WIDTH-1:0]     i_magB,
    output logic [2*WIDTH-1:0]   o_product,
    output logic                 o_lastIter,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mul_state_t           r_state;
    logic [2*WIDTH-1:0]   r_multiplicand;
    logic [2*WIDTH-1:0]   r_accum;
    logic [WIDTH-1:0]     r_multiplier;
    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   w_addend;

    always_comb begin
        w_addend = '0;
        if (r_multiplier[0]) begin
            w_addend = r_multiplicand;
        end
    end

    // o_product is the accumulator after this cycle's add; on the last
    // iteration it is the complete unsigned product.
    assign o_product  = r_accum + w_addend;
    assign o_lastIter = (r_state == ST_CALC) && (r_count == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_accum        <= '0;
            r_count        <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_multiplicand <= {{WIDTH{1'b0}}, i_magA};
                        r_multiplier   <= i_magB;
                        r_accum        <= '0;
                        r_count        <= '0;
                        o_busy         <= 1'b1;
                        r_state        <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_accum        <= o_product;
                    r_multiplicand <= r_multiplicand << 1;
                    r_multiplier   <= r_multiplier >> 1;
                    r_count        <= r_count + 1'b1;
                    if (r_count == LAST_COUNT) begin
                        o_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/multiplier.sv
// RV32M multiplier (MUL/MULH/MULHSU/MULHU): sign capture and magnitude
// conversion around the unsigned shift-add core, then negation and word select.
module multiplier
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  result,
    output logic              busy,
    output logic              done
);

    mul_op_t             r_op;
    logic                r_neg;
    logic [WIDTH-1:0]    r_result;

    logic                w_signA;
    logic                w_signB;
    logic [WIDTH-1:0]    w_magA;
    logic [WIDTH-1:0]    w_magB;
    logic                w_accept;
    logic                w_lastIter;
    logic [2*WIDTH-1:0]  w_product;
    logic [2*WIDTH-1:0]  w_signedProduct;

    // The most negative operand maps to itself, which is its correct unsigned magnitude.
    always_comb begin
        w_signA = opSignedA(mul_op_t'(op)) & a[WIDTH-1];
        w_signB = opSignedB(mul_op_t'(op)) & b[WIDTH-1];
        w_magA  = w_signA ? (~a + 1'b1) : a;
        w_magB  = w_signB ? (~b + 1'b1) : b;
    end

    assign w_accept = start & ~busy;

    multiplier_unsigned #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .i_start    (start),
        .i_magA     (w_magA),
        .i_magB     (w_magB),
        .o_product  (w_product),
        .o_lastIter (w_lastIter),
        .o_busy     (busy),
        .o_done     (done)
    );

    always_comb begin
        w_signedProduct = w_product;
        if (r_neg) begin
            w_signedProduct = ~w_product + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= MUL;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= mul_op_t'(op);
                r_neg <= w_signA ^ w_signB;
            end
            if (w_lastIter) begin
                r_result <= (r_op == MUL) ? w_signedProduct[WIDTH-1:0]
                                          : w_signedProduct[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign result = r_result;

endmodule
